// File: rtl/fp16_to_fix.sv
// Two-stage FP16 to signed fixed-point converter with valid/ready on both sides.
// Stage 1 decodes the operand; stage 2 shifts, rounds half away from zero and saturates.
module fp16_to_fix #(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [3:0]       out_flags
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // Wide enough that an 11-bit significand shifted by the largest k never wraps.
    localparam int WIDE = OUT_W + 80;
    localparam logic [WIDE-1:0]   POS_LIM = (WIDE'(1) << (OUT_W - 1)) - WIDE'(1);
    localparam logic [WIDE-1:0]   NEG_LIM = WIDE'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [8:0] K_NORM_BIAS = 9'(FRAC_W - 25);
    localparam logic signed [8:0] K_DENORM    = 9'(FRAC_W - 24);

    logic              s1_valid_reg;
    logic              s1_sign_reg;
    cls_t              s1_cls_reg;
    logic [10:0]       s1_m_reg;
    logic signed [8:0] s1_k_reg;

    logic              out_valid_reg;
    logic [OUT_W-1:0]  out_data_reg;
    logic [3:0]        out_flags_reg;

    logic s2_load;

    assign s2_load   = ~out_valid_reg | out_ready;
    assign in_ready  = ~s1_valid_reg | s2_load;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_flags = out_flags_reg;

    // Stage 1 decode
    logic [4:0]        exp_f;
    logic [9:0]        frac_f;
    cls_t              dec_cls;
    logic [10:0]       dec_m;
    logic signed [8:0] dec_k;

    assign exp_f  = in_data[14:10];
    assign frac_f = in_data[9:0];

    always_comb begin
        dec_cls = CLS_NORMAL;
        dec_m   = {1'b1, frac_f};
        dec_k   = $signed({4'b0000, exp_f}) + K_NORM_BIAS;
        if (exp_f == 5'd0) begin
            dec_cls = (frac_f == 10'd0) ? CLS_ZERO : CLS_DENORM;
            dec_m   = {1'b0, frac_f};
            dec_k   = K_DENORM;
        end else if (exp_f == 5'd31) begin
            dec_cls = (frac_f == 10'd0) ? CLS_INF : CLS_NAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_sign_reg <= in_data[15];
            s1_cls_reg  <= dec_cls;
            s1_m_reg    <= dec_m;
            s1_k_reg    <= dec_k;
        end
    end

    // Stage 2 shift / round / saturate
    logic [WIDE-1:0]  mag;
    logic             rnd_inexact;
    logic [8:0]       sh_amt;
    logic [10:0]      kept;
    logic [10:0]      rem_mask;
    logic             guard;
    logic [OUT_W-1:0] res_data_next;
    logic [3:0]       res_flags_next;

    always_comb begin
        mag         = '0;
        rnd_inexact = 1'b0;
        sh_amt      = '0;
        kept        = '0;
        rem_mask    = '0;
        guard       = 1'b0;
        if (!s1_k_reg[8]) begin
            mag = WIDE'(s1_m_reg) << s1_k_reg[7:0];
        end else begin
            sh_amt = 9'(-s1_k_reg);
            if (sh_amt >= 9'd12) begin
                rnd_inexact = |s1_m_reg;
            end else begin
                kept        = s1_m_reg >> sh_amt;
                rem_mask    = (11'd1 << sh_amt) - 11'd1;
                // Top bit of the discarded field is the guard bit.
                guard       = |(s1_m_reg & (rem_mask ^ (rem_mask >> 1)));
                rnd_inexact = |(s1_m_reg & rem_mask);
                mag         = WIDE'(kept) + WIDE'(guard);
            end
        end

        res_data_next  = '0;
        res_flags_next = 4'b0000;
        case (s1_cls_reg)
            CLS_NAN:  res_flags_next = 4'b1000;
            CLS_INF: begin
                res_data_next  = s1_sign_reg ? MIN_NEG : MAX_POS;
                res_flags_next = 4'b0110;
            end
            CLS_ZERO: res_flags_next = 4'b0000;
            default: begin
                if (s1_sign_reg ? (mag > NEG_LIM) : (mag > POS_LIM)) begin
                    res_data_next  = s1_sign_reg ? MIN_NEG : MAX_POS;
                    res_flags_next = 4'b0010;
                end else begin
                    res_data_next  = s1_sign_reg ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
                    res_flags_next = {3'b000, rnd_inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_flags_reg <= 4'b0000;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg  <= res_data_next;
                out_flags_reg <= res_flags_next;
            end
        end
    end

endmodule
